// File: rtl/uart_pkg.sv
//==============================================================================
// uart_pkg : shared types and line-level constants for the 8N1 byte transmitter
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic LINE_IDLE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
//==============================================================================
// uart_baud_counter : bit-period timer, registered bit_end pulse on the last
//                     clock of each CLKS_PER_BIT period
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_end
);

   localparam int               CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             bit_end_q;
   logic             bit_end_d;

   // bit_end is computed from the next count so the registered pulse lines
   // up exactly with the cycle in which count_q holds the last value.
   always_comb begin
      count_d = count_q + CNT_W'(1);
      if (clear || (count_q == LAST_COUNT)) begin
         count_d = '0;
      end
      bit_end_d = (count_d == LAST_COUNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         bit_end_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         bit_end_q <= bit_end_d;
      end
   end

   assign bit_end = bit_end_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_byte.sv
//==============================================================================
// uart_tx_byte : single-byte 8N1 UART transmitter with busy/done handshake
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_valid,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       active,
   output logic       done
);

   localparam int                 IDX_W    = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0]   LAST_BIT = IDX_W'(DATA_BITS - 1);

   uart_state_e          state_q;
   uart_state_e          state_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic [IDX_W-1:0]     bit_idx_q;
   logic [IDX_W-1:0]     bit_idx_d;
   logic                 tx_q;
   logic                 tx_d;
   logic                 active_q;
   logic                 active_d;
   logic                 done_q;
   logic                 done_d;

   logic                 bit_end;
   logic                 accept;
   logic                 baud_clear;

   // Strobes while a frame is in flight never reach the shift register.
   assign accept     = (state_q == IDLE) && data_valid;
   assign baud_clear = accept || bit_end;

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (baud_clear),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;
      active_d  = active_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d     = LINE_IDLE;
            active_d = 1'b0;
            if (accept) begin
               shift_d  = data_in;
               tx_d     = START_BIT;
               active_d = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d      = shift_q[0];
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_q == LAST_BIT) begin
                  tx_d    = STOP_BIT;
                  state_d = STOP;
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               active_d = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            tx_d     = LINE_IDLE;
            active_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= LINE_IDLE;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         active_q  <= active_d;
         done_q    <= done_d;
      end
   end

   assign tx     = tx_q;
   assign active = active_q;
   assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_byte.sv
//==============================================================================
// tb_uart_tx_byte : scoreboard bench for uart_tx_byte at CLKS_PER_BIT = 4
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_byte;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       data_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       tx;
   logic       active;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       start_bit;
      logic       stop_bit;
      bit         stable;
   } frame_t;

   frame_t     obs_q[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx_byte #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_valid (data_valid),
      .data_in    (data_in),
      .tx         (tx),
      .active     (active),
      .done       (done)
   );

   // Line monitor: decodes each frame from tx and flags any bit not held
   // at a constant level for its whole CPB-cycle slot.
   int         mon_cnt = 0;
   bit         mon_busy = 0;
   logic [9:0] mon_bits = '1;
   bit         mon_stable = 1;
   frame_t     mon_f;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mon_busy = 0;
         mon_cnt  = 0;
      end else if (!mon_busy) begin
         if (tx === 1'b0) begin
            mon_busy    = 1;
            mon_bits[0] = tx;
            mon_cnt     = 1;
            mon_stable  = 1;
         end
      end else begin
         if (mon_cnt % CPB == 0) mon_bits[mon_cnt / CPB] = tx;
         else if (tx !== mon_bits[mon_cnt / CPB]) mon_stable = 0;
         mon_cnt++;
         if (mon_cnt == FRAME) begin
            mon_f.data      = mon_bits[8:1];
            mon_f.start_bit = mon_bits[0];
            mon_f.stop_bit  = mon_bits[9];
            mon_f.stable    = mon_stable;
            obs_q.push_back(mon_f);
            mon_busy = 0;
         end
      end
   end

   // Strobe one byte; called on a negedge, returns on the first negedge of the frame.
   task automatic send(input logic [7:0] b, input bit expect_frame);
      data_in    = b;
      data_valid = 1'b1;
      if (expect_frame) exp_q.push_back(b);
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   // Counts active and tx-low cycles until done rises; returns on the done negedge.
   task automatic watch(output int act_cycles, output int low_cycles, output bit got_done);
      act_cycles = 0;
      low_cycles = 0;
      got_done   = 0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         if (done === 1'b1) begin
            got_done = 1;
            break;
         end
         if (active === 1'b1) begin
            act_cycles++;
            if (tx === 1'b0) low_cycles++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
      checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle;
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx !== 1'b1 || active !== 1'b0 || done !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_line: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_single;
      int act, low; bit got; frame_t o; logic [7:0] e;
      send(8'h41, 1);
      watch(act, low, got);
      checks++; if (got !== 1'b1)   begin errors++; $display("FAIL single_done: got %b expected 1", got); end
      checks++; if (act !== FRAME)  begin errors++; $display("FAIL single_active_len: got %0d expected %0d", act, FRAME); end
      checks++; if (low !== 28)     begin errors++; $display("FAIL single_low_cycles: got %0d expected 28", low); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_active_at_done: got %b expected 0", active); end
      @(negedge clk);
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL single_done_width: got %b expected 0", done); end
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL single_frame: got no frame expected 41"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.data !== e || o.start_bit !== 1'b0 || o.stop_bit !== 1'b1 || !o.stable) begin
            errors++; $display("FAIL single_frame: got %h s%b p%b st%0d expected %h", o.data, o.start_bit, o.stop_bit, o.stable, e);
         end
      end
   endtask

   task automatic test_back_to_back;
      int act1, low1, act2, low2; bit got1, got2; frame_t o; logic [7:0] e;
      send(8'h55, 1);
      watch(act1, low1, got1);
      // Strobe on the done cycle itself.
      send(8'hAA, 1);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start_immediate: got %b expected 0", tx); end
      watch(act2, low2, got2);
      checks++; if (got1 !== 1'b1 || got2 !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b%b expected 11", got1, got2); end
      checks++; if (act1 !== FRAME || act2 !== FRAME) begin errors++; $display("FAIL b2b_active_len: got %0d,%0d expected %0d", act1, act2, FRAME); end
      checks++; if (low1 !== 20 || low2 !== 20) begin errors++; $display("FAIL b2b_low_cycles: got %0d,%0d expected 20", low1, low2); end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL b2b_frame%0d: got no frame", k); end
         else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.data !== e || o.start_bit !== 1'b0 || o.stop_bit !== 1'b1 || !o.stable) begin
               errors++; $display("FAIL b2b_frame%0d: got %h s%b p%b st%0d expected %h", k, o.data, o.start_bit, o.stop_bit, o.stable, e);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_busy_strobe;
      int act, low, bad; bit got; frame_t o; logic [7:0] e;
      send(8'h00, 1);
      repeat (11) @(negedge clk);
      data_in = 8'hFF; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      watch(act, low, got);
      checks++; if (got !== 1'b1)  begin errors++; $display("FAIL busy_done: got %b expected 1", got); end
      checks++; if (act !== 28)    begin errors++; $display("FAIL busy_active_rest: got %0d expected 28", act); end
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL busy_frame: got no frame expected 00"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.data !== e || o.start_bit !== 1'b0 || o.stop_bit !== 1'b1 || !o.stable) begin
            errors++; $display("FAIL busy_frame: got %h s%b p%b st%0d expected %h", o.data, o.start_bit, o.stop_bit, o.stable, e);
         end
      end
      bad = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || tx !== 1'b1 || active !== 1'b0) bad++;
      end
      checks++; if (bad !== 0 || obs_q.size() !== 0) begin errors++; $display("FAIL busy_dropped: got %0d bad cycles %0d frames expected 0 0", bad, obs_q.size()); end
   endtask

   task automatic test_extremes;
      int act, low; bit got; frame_t o; logic [7:0] e;
      logic [7:0] pat [2];
      int         exp_low [2];
      pat[0] = 8'h00; exp_low[0] = 36;
      pat[1] = 8'hFF; exp_low[1] = 4;
      for (int k = 0; k < 2; k++) begin
         send(pat[k], 1);
         watch(act, low, got);
         checks++; if (got !== 1'b1 || act !== FRAME) begin errors++; $display("FAIL extreme%0d_len: got done=%b act=%0d expected 1 %0d", k, got, act, FRAME); end
         checks++; if (low !== exp_low[k]) begin errors++; $display("FAIL extreme%0d_low: got %0d expected %0d", k, low, exp_low[k]); end
         checks++;
         if (obs_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL extreme%0d_frame: got no frame", k); end
         else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.data !== e || o.start_bit !== 1'b0 || o.stop_bit !== 1'b1 || !o.stable) begin
               errors++; $display("FAIL extreme%0d_frame: got %h s%b p%b st%0d expected %h", k, o.data, o.start_bit, o.stop_bit, o.stable, e);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_frame;
      int act, low; bit got; frame_t o; logic [7:0] e;
      send(8'h3C, 0);
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1 || active !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL midreset_async: got tx=%b active=%b done=%b expected 1 0 0", tx, active, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (obs_q.size() !== 0 || done !== 1'b0) begin errors++; $display("FAIL midreset_abort: got %0d frames done=%b expected 0 0", obs_q.size(), done); end
      send(8'h3C, 1);
      watch(act, low, got);
      checks++; if (got !== 1'b1 || act !== FRAME) begin errors++; $display("FAIL midreset_resend_len: got done=%b act=%0d expected 1 %0d", got, act, FRAME); end
      checks++; if (low !== 20) begin errors++; $display("FAIL midreset_low: got %0d expected 20", low); end
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL midreset_frame: got no frame expected 3c"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o.data !== e || o.start_bit !== 1'b0 || o.stop_bit !== 1'b1 || !o.stable) begin
            errors++; $display("FAIL midreset_frame: got %h s%b p%b st%0d expected %h", o.data, o.start_bit, o.stop_bit, o.stable, e);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_busy_strobe();
      test_extremes();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
